// File: rtl/dcache_pkg.sv
// Shared state encoding and address-field helpers for the MEM-stage data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    WDONE = 2'd3
  } dcacheState_e;

  function automatic int wordBits(input int blockWords);
    return $clog2(blockWords);
  endfunction

  function automatic int indexBits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tagBits(input int lines, input int blockWords);
    return 30 - wordBits(blockWords) - indexBits(lines);
  endfunction

  // Field extractors shift rather than slice so a one-word line (zero word bits) still works.
  function automatic logic [31:0] addrWord(input logic [31:0] addr, input int wb);
    return (addr >> 2) & ((32'd1 << wb) - 32'd1);
  endfunction

  function automatic logic [31:0] addrIndex(input logic [31:0] addr, input int wb, input int ib);
    return (addr >> (2 + wb)) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addrTag(input logic [31:0] addr, input int wb, input int ib);
    return addr >> (2 + wb + ib);
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Data storage for the cache: one flat array addressed by {index, word},
// combinational read for same-cycle hits, synchronous write.
module dcache_data_array #(
  parameter int LINES       = 32,
  parameter int BLOCK_WORDS = 4,
  localparam int AW         = $clog2(LINES * BLOCK_WORDS)
) (
  input  logic          clock,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  logic [31:0]   wrData_i,
  input  logic [AW-1:0] rdAddr_i,
  output logic [31:0]   rdData_o
);

  logic [31:0] words_q [LINES * BLOCK_WORDS];

  always_ff @(posedge clock) begin
    if (wrEn_i) begin
      words_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = words_q[rdAddr_i];

endmodule

// File: rtl/mem_stage_dcache.sv
// Direct-mapped write-through, no-write-allocate MEM-stage data cache with word-serial refill.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module mem_stage_dcache
  import dcache_pkg::*;
#(
  parameter int LINES       = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck,
  output logic [31:0] accessCount,
  output logic [31:0] missCount
);

  localparam int WB  = wordBits(BLOCK_WORDS);
  localparam int IB  = indexBits(LINES);
  localparam int TB  = tagBits(LINES, BLOCK_WORDS);
  localparam int WCW = (WB > 0) ? WB : 1;
  localparam int AW  = WB + IB;
  localparam logic [31:0] LINE_MASK = ~((32'(BLOCK_WORDS) << 2) - 32'd1);

  dcacheState_e state_q, state_d;
  logic [WCW-1:0] wordCnt_q, wordCnt_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic memReq_q, memReq_d, memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d, memWData_q, memWData_d;
  logic [LINES-1:0] valid_q;
  logic [TB-1:0] tag_q [LINES];

  logic [IB-1:0] reqIndex, latIndex;
  logic [TB-1:0] reqTag, latTag;
  logic lookupHit, latHit, ackValid, fillDone;
  logic arrWe;
  logic [AW-1:0] arrWrAddr, arrRdAddr;
  logic [31:0] arrWData, arrRData;

  assign reqIndex  = IB'(addrIndex(address, WB, IB));
  assign reqTag    = TB'(addrTag(address, WB, IB));
  assign latIndex  = IB'(addrIndex(addr_q, WB, IB));
  assign latTag    = TB'(addrTag(addr_q, WB, IB));
  assign lookupHit = valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);
  assign latHit    = valid_q[latIndex] && (tag_q[latIndex] == latTag);
  assign ackValid  = memAck && memReq_q;

  assign arrRdAddr = AW'(address >> 2);
  assign arrWe     = ackValid && ((state_q == FILL) || ((state_q == WRITE) && latHit));
  assign arrWrAddr = (state_q == FILL) ? AW'((32'(latIndex) << WB) | 32'(wordCnt_q))
                                       : AW'(addr_q >> 2);
  assign arrWData  = (state_q == FILL) ? memRData : data_q;

  dcache_data_array #(.LINES(LINES), .BLOCK_WORDS(BLOCK_WORDS)) dataArray (
    .clock   (clock),
    .wrEn_i  (arrWe),
    .wrAddr_i(arrWrAddr),
    .wrData_i(arrWData),
    .rdAddr_i(arrRdAddr),
    .rdData_o(arrRData)
  );

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= IDLE;
      wordCnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWData_q <= '0;
    end else begin
      state_q    <= state_d;
      wordCnt_q  <= wordCnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      valid_q <= '0;
    end else if (fillDone) begin
      valid_q[latIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fillDone) begin
      tag_q[latIndex] <= latTag;
    end
  end

  // Requests are launched from IDLE so the backing-memory port is registered; a write wins over a read.
  always_comb begin
    state_d    = state_q;
    wordCnt_d  = wordCnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWData_d = memWData_q;
    fillDone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memWrite) begin
          state_d    = WRITE;
          addr_d     = address;
          data_d     = writeData;
          memReq_d   = 1'b1;
          memWe_d    = 1'b1;
          memAddr_d  = address & ~32'd3;
          memWData_d = writeData;
        end else if (memRead && !lookupHit) begin
          state_d   = FILL;
          addr_d    = address;
          wordCnt_d = '0;
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = address & LINE_MASK;
        end
      end
      FILL: begin
        if (ackValid) begin
          if (wordCnt_q == WCW'(BLOCK_WORDS - 1)) begin
            state_d   = IDLE;
            memReq_d  = 1'b0;
            wordCnt_d = '0;
            fillDone  = 1'b1;
          end else begin
            wordCnt_d = wordCnt_q + WCW'(1);
            memAddr_d = memAddr_q + 32'd4;
          end
        end
      end
      WRITE: begin
        if (ackValid) begin
          state_d  = WDONE;
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    hit      = 1'b0;
    readData = '0;
    if (!resetN) begin
      hit = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (memWrite) begin
            hit = 1'b0;
          end else if (memRead) begin
            hit = lookupHit;
            if (lookupHit) begin
              readData = arrRData;
            end
          end else begin
            hit = 1'b1;
          end
        end
        WDONE:   hit = 1'b1;
        default: hit = 1'b0;
      endcase
    end
  end

  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memAddr  = memAddr_q;
  assign memWData = memWData_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] accessCount_q, missCount_q;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      accessCount_q <= '0;
      missCount_q   <= '0;
    end else begin
      if (hit && (memRead || memWrite)) begin
        accessCount_q <= accessCount_q + 32'd1;
      end
      if ((state_q == IDLE) && (state_d == FILL)) begin
        missCount_q <= missCount_q + 32'd1;
      end
    end
  end

  assign accessCount = accessCount_q;
  assign missCount   = missCount_q;
`else
  assign accessCount = '0;
  assign missCount   = '0;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed self-checking bench for mem_stage_dcache with a word-serial backing-memory responder.
module tb_mem_stage_dcache;

  logic        clock = 1'b0;
  logic        resetN, memRead, memWrite, memAck;
  logic [31:0] address, writeData, memRData;
  logic [31:0] readData, memAddr, memWData, accessCount, missCount;
  logic        hit, memReq, memWe;

  int total = 0;
  int bad   = 0;

  logic [31:0] backing [logic [31:0]];

  mem_stage_dcache #(.LINES(32), .BLOCK_WORDS(4)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData),
    .hit        (hit),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memRData   (memRData),
    .memAck     (memAck),
    .accessCount(accessCount),
    .missCount  (missCount)
  );

  always #5 clock = ~clock;

  // Unwritten backing words read as {addr[15:0], ~addr[15:0]}.
  function automatic logic [31:0] backingWord(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    memRead   = rd;
    memWrite  = wr;
    address   = addr;
    writeData = wdata;
    #1;
  endtask

  task automatic serviceRequest(input string tag, input logic [31:0] expAddr, input logic expWe,
                                input logic [31:0] expWData);
    int waited = 0;
    while (memReq !== 1'b1 && waited < 20) begin
      @(negedge clock);
      #1;
      waited++;
    end
    checkOutput({tag, ".req"}, 32'(memReq), 32'd1);
    checkOutput({tag, ".addr"}, memAddr, expAddr);
    checkOutput({tag, ".we"}, 32'(memWe), 32'(expWe));
    if (expWe) checkOutput({tag, ".wdata"}, memWData, expWData);
    checkOutput({tag, ".stall"}, 32'(hit), 32'd0);
    @(negedge clock);
    #1;
    checkOutput({tag, ".hold"}, 32'(memReq), 32'd1);
    if (expWe) backing[expAddr] = expWData;
    memRData = backingWord(expAddr);
    memAck   = 1'b1;
    @(negedge clock);
    memAck   = 1'b0;
    memRData = 32'hBAD0_BAD0;
    #1;
  endtask

  initial begin
    resetN    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    address   = '0;
    writeData = '0;
    memRData  = '0;
    memAck    = 1'b0;

    // Reset with a load pending: no stall, no data.
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("rst.hit", 32'(hit), 32'd1);
    checkOutput("rst.rdata", readData, 32'h0);
    @(negedge clock);
    #1;
    checkOutput("rst.memReq", 32'(memReq), 32'd0);
    checkOutput("rst.memWe", 32'(memWe), 32'd0);
    checkOutput("rst.memAddr", memAddr, 32'h0);
    checkOutput("rst.memWData", memWData, 32'h0);
    checkOutput("rst.access", accessCount, 32'd0);
    checkOutput("rst.miss", missCount, 32'd0);
    resetN  = 1'b1;
    memRead = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("idle.hit", 32'(hit), 32'd1);

    // Stray ack with no request outstanding.
    memAck   = 1'b1;
    memRData = 32'h1234_5678;
    @(negedge clock);
    memAck = 1'b0;
    #1;
    checkOutput("stray.memReq", 32'(memReq), 32'd0);
    checkOutput("stray.hit", 32'(hit), 32'd1);

    // Test 1: cold load of 0x40 fills the whole line.
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t1.missHit", 32'(hit), 32'd0);
    checkOutput("t1.missData", readData, 32'h0);
    serviceRequest("t1.w0", 32'h40, 1'b0, 32'h0);
    serviceRequest("t1.w1", 32'h44, 1'b0, 32'h0);
    serviceRequest("t1.w2", 32'h48, 1'b0, 32'h0);
    serviceRequest("t1.w3", 32'h4C, 1'b0, 32'h0);
    checkOutput("t1.hit", 32'(hit), 32'd1);
    checkOutput("t1.rdata", readData, 32'h0040_FFBF);
    checkOutput("t1.reqDone", 32'(memReq), 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("t1.miss", missCount, 32'd1);
`endif

    // Test 2: same-line load hits combinationally.
    applyStimulus(1'b1, 1'b0, 32'h48, 32'h0);
    checkOutput("t2.hit", 32'(hit), 32'd1);
    checkOutput("t2.rdata", readData, 32'h0048_FFB7);
    checkOutput("t2.noReq", 32'(memReq), 32'd0);

    // Test 3: store to a cached word, then read it back.
    applyStimulus(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF);
    checkOutput("t3.stall", 32'(hit), 32'd0);
    serviceRequest("t3.wr", 32'h44, 1'b1, 32'hDEAD_BEEF);
    checkOutput("t3.wdoneHit", 32'(hit), 32'd1);
    checkOutput("t3.wdoneReq", 32'(memReq), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
    checkOutput("t3.hit", 32'(hit), 32'd1);
    checkOutput("t3.rdata", readData, 32'hDEAD_BEEF);

    // Test 4: uncached store is write-through only; read+write together acts as a write.
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h1234_5678);
    checkOutput("t4.stall", 32'(hit), 32'd0);
    serviceRequest("t4.wr", 32'h1000, 1'b1, 32'h1234_5678);
    checkOutput("t4.wdoneHit", 32'(hit), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t4.hit40", 32'(hit), 32'd1);
    checkOutput("t4.rdata40", readData, 32'h0040_FFBF);
    applyStimulus(1'b1, 1'b1, 32'h4A, 32'hCAFE_F00D);
    checkOutput("t4.rwStall", 32'(hit), 32'd0);
    checkOutput("t4.rwData", readData, 32'h0);
    serviceRequest("t4.rw", 32'h48, 1'b1, 32'hCAFE_F00D);
    checkOutput("t4.rwDone", 32'(hit), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'h0);
    checkOutput("t4.rdata48", readData, 32'hCAFE_F00D);

    // Test 5: conflicting line 0x240 evicts 0x40, which then refills from backing memory.
    applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
    checkOutput("t5.miss240", 32'(hit), 32'd0);
    serviceRequest("t5.a0", 32'h240, 1'b0, 32'h0);
    serviceRequest("t5.a1", 32'h244, 1'b0, 32'h0);
    serviceRequest("t5.a2", 32'h248, 1'b0, 32'h0);
    serviceRequest("t5.a3", 32'h24C, 1'b0, 32'h0);
    checkOutput("t5.hit240", 32'(hit), 32'd1);
    checkOutput("t5.rdata240", readData, 32'h0240_FDBF);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t5.miss40", 32'(hit), 32'd0);
    serviceRequest("t5.b0", 32'h40, 1'b0, 32'h0);
    serviceRequest("t5.b1", 32'h44, 1'b0, 32'h0);
    serviceRequest("t5.b2", 32'h48, 1'b0, 32'h0);
    serviceRequest("t5.b3", 32'h4C, 1'b0, 32'h0);
    checkOutput("t5.rdata40", readData, 32'h0040_FFBF);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
    checkOutput("t5.rdata44", readData, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h48, 32'h0);
    checkOutput("t5.rdata48", readData, 32'hCAFE_F00D);

    // Test 6: reset in the middle of a fill abandons it and invalidates the cache.
    applyStimulus(1'b1, 1'b0, 32'h240, 32'h0);
    serviceRequest("t6.a0", 32'h240, 1'b0, 32'h0);
    serviceRequest("t6.a1", 32'h244, 1'b0, 32'h0);
    checkOutput("t6.midReq", 32'(memReq), 32'd1);
    checkOutput("t6.midAddr", memAddr, 32'h248);
`ifdef DCACHE_STATS_EN
    checkOutput("t6.missPre", missCount, 32'd4);
`endif
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checkOutput("t6.rstHit", 32'(hit), 32'd1);
    checkOutput("t6.rstData", readData, 32'h0);
    @(negedge clock);
    #1;
    checkOutput("t6.rstReq", 32'(memReq), 32'd0);
    checkOutput("t6.rstAddr", memAddr, 32'h0);
    checkOutput("t6.rstMiss", missCount, 32'd0);
    checkOutput("t6.rstAccess", accessCount, 32'd0);
    resetN  = 1'b1;
    memRead = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    checkOutput("t6.miss40", 32'(hit), 32'd0);
    serviceRequest("t6.b0", 32'h40, 1'b0, 32'h0);
    serviceRequest("t6.b1", 32'h44, 1'b0, 32'h0);
    serviceRequest("t6.b2", 32'h48, 1'b0, 32'h0);
    serviceRequest("t6.b3", 32'h4C, 1'b0, 32'h0);
    checkOutput("t6.hit40", 32'(hit), 32'd1);
    checkOutput("t6.rdata40", readData, 32'h0040_FFBF);
`ifdef DCACHE_STATS_EN
    checkOutput("t6.missPost", missCount, 32'd1);
    checkOutput("t6.accessPre", accessCount, 32'd0);
`else
    checkOutput("t6.missOff", missCount, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DCACHE_STATS_EN
    checkOutput("t6.accessPost", accessCount, 32'd1);
`else
    checkOutput("t6.accessOff", accessCount, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
